// File: rtl/decode_align.sv
// Instruction-window aligner: pulls 15-byte decode windows out of the 128-byte fetch ring
// and tracks the RIP of window byte 0 as the decoder consumes instructions.
module decode_align (
   input  logic          clk,
   input  logic          reset,
   input  logic [63:0]   entry,
   input  logic [6:0]    fetch_offset_in,
   input  logic [0:1023] decode_buffer_in,
   output logic [6:0]    decode_offset_in,
   output logic [0:119]  window,
   output logic          window_valid,
   output logic [63:0]   window_rip,
   input  logic          consume_valid,
   input  logic [3:0]    consume_len,
   output logic [31:0]   insn_count,
   output logic          error
);

   localparam logic [1:0] ALIGN = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] VALID = 2'd2;
   localparam logic [1:0] HALT  = 2'd3;

   logic [1:0]   state_q, state_d;
   logic [6:0]   decodeOffset_q, decodeOffset_d;
   logic [0:119] window_q, window_d;
   logic [63:0]  rip_q, rip_d;
   logic [31:0]  count_q, count_d;
   logic         error_q, error_d;
   logic [2:0]   alignOffset_q;

   logic [6:0]   avail;
   logic [6:0]   advancedOffset;
   logic [7:0]   availAfter;
   logic         stayValid;

   function automatic logic [0:119] gatherWindow(input logic [0:1023] image,
                                                 input logic [6:0]    base);
      logic [0:119] w;
      logic [6:0]   idx;
      w = '0;
      for (int i = 0; i < 15; i++) begin
         idx = base + 7'(i);
         w[i*8 +: 8] = image[{idx, 3'b000} +: 8];
      end
      return w;
   endfunction

   // 7-bit subtraction wraps naturally around the ring; 8-bit difference exposes an over-consume
   assign avail          = fetch_offset_in - decodeOffset_q;
   assign advancedOffset = decodeOffset_q + {3'b000, consume_len};
   assign availAfter     = {1'b0, avail} - {4'b0000, consume_len};
   assign stayValid      = !availAfter[7] && (availAfter >= 8'd15);

   always_comb begin
      state_d        = state_q;
      decodeOffset_d = decodeOffset_q;
      window_d       = window_q;
      rip_d          = rip_q;
      count_d        = count_q;
      error_d        = error_q;
      case (state_q)
         ALIGN: begin
            if (avail >= 7'd8) begin
               decodeOffset_d = {4'b0000, alignOffset_q};
               state_d        = WAIT;
            end
         end
         WAIT: begin
            if (avail >= 7'd15) begin
               window_d = gatherWindow(decode_buffer_in, decodeOffset_q);
               state_d  = VALID;
            end
         end
         VALID: begin
            if (consume_valid) begin
               if (consume_len == 4'd0) begin
                  state_d = HALT;
                  error_d = 1'b1;
               end else begin
                  decodeOffset_d = advancedOffset;
                  rip_d          = rip_q + {60'd0, consume_len};
                  count_d        = count_q + 32'd1;
                  // Reload in place when enough bytes remain, sustaining one instruction per cycle
                  if (stayValid) begin
                     window_d = gatherWindow(decode_buffer_in, advancedOffset);
                  end else begin
                     state_d = WAIT;
                  end
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ALIGN;
         decodeOffset_q <= '0;
         window_q       <= '0;
         rip_q          <= entry;
         count_q        <= '0;
         error_q        <= 1'b0;
         alignOffset_q  <= entry[2:0];
      end else begin
         state_q        <= state_d;
         decodeOffset_q <= decodeOffset_d;
         window_q       <= window_d;
         rip_q          <= rip_d;
         count_q        <= count_d;
         error_q        <= error_d;
      end
   end

   assign decode_offset_in = decodeOffset_q;
   assign window           = window_q;
   assign window_valid     = (state_q == VALID);
   assign window_rip       = rip_q;
   assign insn_count       = count_q;
   assign error            = error_q;

endmodule

// File: tb/tb_decode_align.sv
// Scoreboarded bench for decode_align: a behavioural model predicts every cycle's outputs,
// with directed checks on the alignment, back-to-back, wrap, reset and halt scenarios.
module tb_decode_align;

   logic          clk = 1'b0;
   logic          reset;
   logic [63:0]   entry;
   logic [6:0]    fetch_offset_in;
   logic [0:1023] bufferImage;
   logic [6:0]    decode_offset_in;
   logic [0:119]  window;
   logic          window_valid;
   logic [63:0]   window_rip;
   logic          consume_valid;
   logic [3:0]    consume_len;
   logic [31:0]   insn_count;
   logic          error;

   int vectorCount = 0;
   int failCount   = 0;

   typedef struct {
      logic [6:0]   off;
      logic [0:119] win;
      logic         valid;
      logic [63:0]  rip;
      logic [31:0]  cnt;
      logic         err;
   } expT;

   expT expQ[$];

   // Reference model state: 0 align, 1 wait, 2 valid, 3 halt
   int           mState;
   int           mOff;
   logic [0:119] mWin;
   logic [63:0]  mRip;
   logic [31:0]  mCnt;
   logic         mErr;
   logic [2:0]   mAlign;

   decode_align dut (
      .clk              (clk),
      .reset            (reset),
      .entry            (entry),
      .fetch_offset_in  (fetch_offset_in),
      .decode_buffer_in (bufferImage),
      .decode_offset_in (decode_offset_in),
      .window           (window),
      .window_valid     (window_valid),
      .window_rip       (window_rip),
      .consume_valid    (consume_valid),
      .consume_len      (consume_len),
      .insn_count       (insn_count),
      .error            (error)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [0:119] modelWindow(input int base);
      logic [0:119] w;
      for (int i = 0; i < 15; i++) begin
         w[i*8 +: 8] = bufferImage[((base + i) % 128) * 8 +: 8];
      end
      return w;
   endfunction

   task automatic modelStep(input logic rst, input logic [6:0] fetch, input logic cv,
                            input logic [3:0] len);
      int avail;
      avail = (int'(fetch) - mOff + 128) % 128;
      if (rst) begin
         mState = 0; mOff = 0; mWin = '0; mRip = entry; mCnt = 0; mErr = 1'b0;
         mAlign = entry[2:0];
      end else begin
         case (mState)
            0: if (avail >= 8) begin mOff = int'(mAlign); mState = 1; end
            1: if (avail >= 15) begin mWin = modelWindow(mOff); mState = 2; end
            2: if (cv) begin
                  if (len == 4'd0) begin
                     mState = 3; mErr = 1'b1;
                  end else begin
                     mOff = (mOff + int'(len)) % 128;
                     mRip = mRip + 64'(len);
                     mCnt = mCnt + 32'd1;
                     if (avail - int'(len) >= 15) mWin = modelWindow(mOff);
                     else mState = 1;
                  end
               end
            default: ;
         endcase
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic [6:0] fetch, input logic cv,
                                input logic [3:0] len);
      expT e;
      @(negedge clk);
      reset = rst; fetch_offset_in = fetch; consume_valid = cv; consume_len = len;
      modelStep(rst, fetch, cv, len);
      e.off = 7'(mOff); e.win = mWin; e.valid = (mState == 2);
      e.rip = mRip; e.cnt = mCnt; e.err = mErr;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         checkOutput("scoreboard empty", 128'd1, 128'd0);
      end else begin
         e = expQ.pop_front();
         checkOutput("offset", decode_offset_in, e.off);
         checkOutput("window", window, e.win);
         checkOutput("valid", window_valid, e.valid);
         checkOutput("rip", window_rip, e.rip);
         checkOutput("count", insn_count, e.cnt);
         checkOutput("error", error, e.err);
      end
   endtask

   logic [0:119] expWin;

   initial begin
      for (int k = 0; k < 128; k++) bufferImage[k*8 +: 8] = 8'(k);
      reset = 1'b1; fetch_offset_in = '0; consume_valid = 1'b0; consume_len = '0;
      entry = 64'h1003;

      // Alignment from a misaligned entry, then the wait for a full window
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("reset rip", window_rip, 64'h1003);
      checkOutput("reset offset", decode_offset_in, 7'd0);
      checkOutput("reset valid", window_valid, 1'b0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 8, 0, 0);
      checkOutput("align offset", decode_offset_in, 7'd3);
      applyStimulus(0, 8, 1, 3);
      checkOutput("ignored consume count", insn_count, 32'd0);
      checkOutput("ignored consume offset", decode_offset_in, 7'd3);
      applyStimulus(0, 17, 0, 0);
      checkOutput("avail14 valid", window_valid, 1'b0);
      applyStimulus(0, 18, 0, 0);
      checkOutput("avail15 valid", window_valid, 1'b1);
      checkOutput("first byte", window[0:7], 8'd3);

      // Aligned entry, full window of bytes 0..14
      entry = 64'h1000;
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 32, 0, 0);
      checkOutput("one cycle valid", window_valid, 1'b0);
      applyStimulus(0, 32, 0, 0);
      for (int i = 0; i < 15; i++) expWin[i*8 +: 8] = 8'(i);
      checkOutput("two cycle valid", window_valid, 1'b1);
      checkOutput("window 0..14", window, expWin);
      checkOutput("window rip", window_rip, 64'h1000);

      // Back-to-back consumes
      applyStimulus(0, 64, 1, 3);
      checkOutput("b2b valid 1", window_valid, 1'b1);
      checkOutput("b2b rip 1", window_rip, 64'h1003);
      applyStimulus(0, 64, 1, 5);
      checkOutput("b2b valid 2", window_valid, 1'b1);
      checkOutput("b2b rip 2", window_rip, 64'h1008);
      checkOutput("b2b offset", decode_offset_in, 7'd8);
      checkOutput("b2b count", insn_count, 32'd2);

      // Walk the read pointer to 120, then wrap the window around the ring
      for (int k = 0; k < 7; k++) applyStimulus(0, 7'((mOff + 64) % 128), 1, 15);
      checkOutput("walk offset", decode_offset_in, 7'd113);
      applyStimulus(0, 8, 1, 7);
      for (int i = 0; i < 15; i++) expWin[i*8 +: 8] = 8'((120 + i) % 128);
      checkOutput("wrap offset", decode_offset_in, 7'd120);
      checkOutput("wrap window", window, expWin);
      checkOutput("wrap valid", window_valid, 1'b1);
      applyStimulus(0, 8, 1, 4);
      checkOutput("wrap consume offset", decode_offset_in, 7'd124);
      checkOutput("wrap to wait", window_valid, 1'b0);
      checkOutput("wrap count", insn_count, 32'd11);

      // Reset while valid with a consume pending
      applyStimulus(0, 60, 0, 0);
      checkOutput("refill valid", window_valid, 1'b1);
      entry = 64'h2000;
      applyStimulus(1, 60, 1, 3);
      checkOutput("mid reset count", insn_count, 32'd0);
      checkOutput("mid reset valid", window_valid, 1'b0);
      checkOutput("mid reset rip", window_rip, 64'h2000);
      checkOutput("mid reset window", window, 120'd0);

      // Zero-length consume halts until reset
      applyStimulus(0, 64, 0, 0);
      applyStimulus(0, 64, 0, 0);
      applyStimulus(0, 64, 1, 0);
      checkOutput("halt error", error, 1'b1);
      checkOutput("halt valid", window_valid, 1'b0);
      for (int k = 0; k < 4; k++) applyStimulus(0, 7'(70 + k), 1, 5);
      checkOutput("halt sticky error", error, 1'b1);
      checkOutput("halt sticky valid", window_valid, 1'b0);
      checkOutput("halt offset", decode_offset_in, 7'd0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("error cleared", error, 1'b0);

      // Random traffic over random buffer contents and entry
      for (int k = 0; k < 128; k++) bufferImage[k*8 +: 8] = 8'($urandom_range(0, 255));
      entry = {$urandom, $urandom};
      applyStimulus(1, 0, 0, 0);
      for (int k = 0; k < 150; k++) begin
         applyStimulus(0, 7'((mOff + int'($urandom_range(16, 80))) % 128),
                       1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule
